ex_md_issue: RTL and testbench

EX_MD_ISSUE -- requirements
Module: ex_md_issue

---
 rtl/ex_md_issue.sv | 112 +++++++++++
 tb/tb_ex_md_issue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_md_issue.sv
// rtl/ex_md_issue.sv - D->E issue register with multiply/divide-busy interlock.
// Optional MD_PERF_CNT_EN adds saturating MD stall cycle/event counters.
module ex_md_issue #(
  parameter logic [3:0] MD_FIRST = 4'b0010,
  parameter logic [3:0] MD_LAST  = 4'b1001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_rs_val,
  input  logic [31:0] d_rt_val,
  input  logic [3:0]  d_hiloop,
  input  logic        d_regwrite,
  input  logic [4:0]  d_wa,
  input  logic        ext_stall,
  input  logic        e_clr,
  input  logic        md_busy,
  output logic [31:0] e_pc,
  output logic [31:0] e_d1,
  output logic [31:0] e_d2,
  output logic [3:0]  e_hiloop,
  output logic        e_regwrite,
  output logic [4:0]  e_wa,
`ifdef MD_PERF_CNT_EN
  output logic [31:0] md_stall_cycles,
  output logic [15:0] md_stall_events,
`endif
  output logic        stall_d,
  output logic        md_stall
);

  typedef enum logic {RUN = 1'b0, MDWAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        d_is_md;
  logic        bubble;
  logic [31:0] e_pc_q, e_d1_q, e_d2_q;
  logic [3:0]  e_hiloop_q;
  logic        e_regwrite_q;
  logic [4:0]  e_wa_q;

  assign d_is_md  = (d_hiloop >= MD_FIRST) && (d_hiloop <= MD_LAST);
  assign md_stall = d_is_md & md_busy;
  assign stall_d  = md_stall | ext_stall;
  assign bubble   = stall_d | e_clr;

  // E never holds: a stalled D instruction leaves a bubble behind it.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      e_pc_q       <= '0;
      e_d1_q       <= '0;
      e_d2_q       <= '0;
      e_hiloop_q   <= '0;
      e_regwrite_q <= 1'b0;
      e_wa_q       <= '0;
    end else begin
      e_pc_q       <= d_pc;
      e_d1_q       <= d_rs_val;
      e_d2_q       <= d_rt_val;
      e_hiloop_q   <= d_hiloop;
      e_regwrite_q <= d_regwrite;
      e_wa_q       <= d_wa;
    end
  end

  assign e_pc       = e_pc_q;
  assign e_d1       = e_d1_q;
  assign e_d2       = e_d2_q;
  assign e_hiloop   = e_hiloop_q;
  assign e_regwrite = e_regwrite_q;
  assign e_wa       = e_wa_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (md_stall)  state_d = MDWAIT;
      MDWAIT:  if (!md_stall) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

`ifdef MD_PERF_CNT_EN
  logic [31:0] cycles_q, cycles_d;
  logic [15:0] events_q, events_d;

  always_comb begin
    cycles_d = cycles_q;
    events_d = events_q;
    if (md_stall && (cycles_q != '1)) cycles_d = cycles_q + 32'd1;
    if (md_stall && (state_q == RUN) && (events_q != '1)) events_d = events_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycles_q <= '0;
      events_q <= '0;
    end else begin
      cycles_q <= cycles_d;
      events_q <= events_d;
    end
  end

  assign md_stall_cycles = cycles_q;
  assign md_stall_events = events_q;
`endif

endmodule

// File: tb/tb_ex_md_issue.sv
// tb/tb_ex_md_issue.sv - scoreboard bench for ex_md_issue.
module tb_ex_md_issue;

  typedef logic [105:0] e_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d_pc, d_rs_val, d_rt_val;
  logic [3:0]  d_hiloop;
  logic        d_regwrite;
  logic [4:0]  d_wa;
  logic        ext_stall, e_clr, md_busy;
  logic [31:0] e_pc, e_d1, e_d2;
  logic [3:0]  e_hiloop;
  logic        e_regwrite;
  logic [4:0]  e_wa;
  logic        stall_d, md_stall;
`ifdef MD_PERF_CNT_EN
  logic [31:0] md_stall_cycles;
  logic [15:0] md_stall_events;
`endif

  int checks = 0;
  int errors = 0;
  e_t sb[$];
  e_t exp_e;

  always #5 clk = ~clk;

  ex_md_issue dut (
    .clk(clk), .reset(reset),
    .d_pc(d_pc), .d_rs_val(d_rs_val), .d_rt_val(d_rt_val),
    .d_hiloop(d_hiloop), .d_regwrite(d_regwrite), .d_wa(d_wa),
    .ext_stall(ext_stall), .e_clr(e_clr), .md_busy(md_busy),
    .e_pc(e_pc), .e_d1(e_d1), .e_d2(e_d2),
    .e_hiloop(e_hiloop), .e_regwrite(e_regwrite), .e_wa(e_wa),
`ifdef MD_PERF_CNT_EN
    .md_stall_cycles(md_stall_cycles), .md_stall_events(md_stall_events),
`endif
    .stall_d(stall_d), .md_stall(md_stall)
  );

  function automatic logic model_md_stall();
    return (d_hiloop >= 4'd2) && (d_hiloop <= 4'd9) && md_busy;
  endfunction

  function automatic logic model_stall();
    return model_md_stall() | ext_stall;
  endfunction

  function automatic e_t model_e();
    if (reset || model_stall() || e_clr) return '0;
    return {d_pc, d_rs_val, d_rt_val, d_hiloop, d_regwrite, d_wa};
  endfunction

  function automatic e_t obs_e();
    return {e_pc, e_d1, e_d2, e_hiloop, e_regwrite, e_wa};
  endfunction

  task automatic set_d(input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [3:0] op, input logic rw, input logic [4:0] wa);
    d_pc = pc; d_rs_val = rs; d_rt_val = rt; d_hiloop = op; d_regwrite = rw; d_wa = wa;
  endtask

  // Records the expected E contents for the inputs now applied, then advances one cycle.
  task automatic tick();
    sb.push_back(model_e());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ext_stall = 1'b0; e_clr = 1'b0; md_busy = 1'b1;
    set_d(32'h1234, 32'd5, 32'd9, 4'b0010, 1'b1, 5'd3);
    #1;
    checks++;
    if (stall_d !== 1'b1) begin errors++; $display("FAIL reset_stall_comb got=%b exp=1", stall_d); end
    tick();
    tick();
    exp_e = sb.pop_front();
    exp_e = sb.pop_front();
    checks++;
    if (obs_e() !== exp_e) begin errors++; $display("FAIL reset_e got=%h exp=%h", obs_e(), exp_e); end
    checks++;
    if (dut.state_q !== 1'b0) begin errors++; $display("FAIL reset_state got=%b exp=0", dut.state_q); end
    md_busy = 1'b0;
    tick();
    exp_e = sb.pop_front();
    reset = 1'b0;
  endtask

  task automatic test_pass_through();
    md_busy = 1'b0;
    set_d(32'h3000, 32'd7, 32'd3, 4'b0010, 1'b0, 5'd0);
    #1;
    checks++;
    if (stall_d !== 1'b0) begin errors++; $display("FAIL pass_stall got=%b exp=0", stall_d); end
    tick();
    exp_e = sb.pop_front();
    checks++;
    if (obs_e() !== exp_e) begin errors++; $display("FAIL pass_e got=%h exp=%h", obs_e(), exp_e); end
    checks++;
    if (e_hiloop !== 4'b0010 || e_pc !== 32'h3000) begin
      errors++; $display("FAIL pass_fields got pc=%h op=%h exp pc=3000 op=2", e_pc, e_hiloop);
    end
  endtask

  task automatic test_mult_mfhi();
    md_busy = 1'b0;
    set_d(32'h4000, 32'd6, 32'd7, 4'b0010, 1'b0, 5'd0);
    tick();
    exp_e = sb.pop_front();
    set_d(32'h4004, 32'd0, 32'd0, 4'b0110, 1'b1, 5'd9);
    md_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (stall_d !== model_stall() || md_stall !== model_md_stall()) begin
        errors++; $display("FAIL mfhi_stall c%0d got=%b/%b exp=1/1", i, stall_d, md_stall);
      end
      tick();
      exp_e = sb.pop_front();
      checks++;
      if (obs_e() !== exp_e) begin errors++; $display("FAIL mfhi_bubble c%0d got=%h exp=%h", i, obs_e(), exp_e); end
    end
    checks++;
    if (dut.state_q !== 1'b1) begin errors++; $display("FAIL mfhi_state got=%b exp=1", dut.state_q); end
    md_busy = 1'b0;
    #1;
    checks++;
    if (stall_d !== 1'b0) begin errors++; $display("FAIL mfhi_release got=%b exp=0", stall_d); end
    tick();
    exp_e = sb.pop_front();
    checks++;
    if (obs_e() !== exp_e || e_hiloop !== 4'b0110) begin
      errors++; $display("FAIL mfhi_issue got=%h exp=%h", obs_e(), exp_e);
    end
  endtask

  task automatic test_non_md_busy();
    md_busy = 1'b1;
    set_d(32'h5000, 32'd1, 32'd2, 4'b0000, 1'b1, 5'd8);
    #1;
    checks++;
    if (stall_d !== 1'b0) begin errors++; $display("FAIL nonmd_stall got=%b exp=0", stall_d); end
    tick();
    exp_e = sb.pop_front();
    checks++;
    if (obs_e() !== exp_e || e_regwrite !== 1'b1 || e_wa !== 5'd8) begin
      errors++; $display("FAIL nonmd_e got=%h exp=%h", obs_e(), exp_e);
    end
    md_busy = 1'b0;
  endtask

  task automatic test_boundary();
    logic [3:0] ops [4];
    logic       exp_s [4];
    ops = '{4'd1, 4'd2, 4'd9, 4'd10};
    exp_s = '{1'b0, 1'b1, 1'b1, 1'b0};
    md_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_d(32'h6000 + 32'(i), 32'd11, 32'd12, ops[i], 1'b0, 5'd0);
      #1;
      checks++;
      if (md_stall !== exp_s[i] || stall_d !== exp_s[i]) begin
        errors++; $display("FAIL boundary op=%0d got=%b exp=%b", ops[i], md_stall, exp_s[i]);
      end
      tick();
      exp_e = sb.pop_front();
      checks++;
      if (obs_e() !== exp_e) begin errors++; $display("FAIL boundary_e op=%0d got=%h exp=%h", ops[i], obs_e(), exp_e); end
    end
    md_busy = 1'b0;
  endtask

  task automatic test_eclr();
    md_busy = 1'b0; ext_stall = 1'b1; e_clr = 1'b1;
    set_d(32'h7000, 32'd4, 32'd5, 4'b0011, 1'b1, 5'd2);
    #1;
    checks++;
    if (stall_d !== 1'b1) begin errors++; $display("FAIL eclr_stall got=%b exp=1", stall_d); end
    tick();
    exp_e = sb.pop_front();
    checks++;
    if (obs_e() !== exp_e) begin errors++; $display("FAIL eclr_bubble got=%h exp=%h", obs_e(), exp_e); end
    ext_stall = 1'b0; e_clr = 1'b0;
    tick();
    exp_e = sb.pop_front();
    checks++;
    if (obs_e() !== exp_e) begin errors++; $display("FAIL eclr_resume got=%h exp=%h", obs_e(), exp_e); end
    e_clr = 1'b1;
    #1;
    checks++;
    if (stall_d !== 1'b0) begin errors++; $display("FAIL eclr_only_stall got=%b exp=0", stall_d); end
    tick();
    exp_e = sb.pop_front();
    checks++;
    if (obs_e() !== exp_e) begin errors++; $display("FAIL eclr_only got=%h exp=%h", obs_e(), exp_e); end
    e_clr = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    md_busy = 1'b1;
    set_d(32'h8000, 32'd21, 32'd22, 4'b0100, 1'b0, 5'd0);
    tick();
    exp_e = sb.pop_front();
    reset = 1'b1;
    tick();
    exp_e = sb.pop_front();
    checks++;
    if (obs_e() !== exp_e || dut.state_q !== 1'b0) begin
      errors++; $display("FAIL midstall_reset got=%h st=%b exp=%h st=0", obs_e(), dut.state_q, exp_e);
    end
    reset = 1'b0; md_busy = 1'b0;
    set_d(32'h8100, 32'd31, 32'd32, 4'b0000, 1'b1, 5'd4);
    tick();
    exp_e = sb.pop_front();
    checks++;
    if (obs_e() !== exp_e) begin errors++; $display("FAIL midstall_next got=%h exp=%h", obs_e(), exp_e); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      set_d($urandom, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom), 5'($urandom));
      md_busy   = 1'($urandom);
      ext_stall = ($urandom_range(0, 3) == 0);
      e_clr     = ($urandom_range(0, 4) == 0);
      #1;
      checks++;
      if (stall_d !== model_stall()) begin errors++; $display("FAIL rand_stall i=%0d got=%b exp=%b", i, stall_d, model_stall()); end
      tick();
      exp_e = sb.pop_front();
      checks++;
      if (obs_e() !== exp_e) begin errors++; $display("FAIL rand_e i=%0d got=%h exp=%h", i, obs_e(), exp_e); end
    end
    ext_stall = 1'b0; e_clr = 1'b0; md_busy = 1'b0;
  endtask

`ifdef MD_PERF_CNT_EN
  task automatic test_perf();
    reset = 1'b1; md_busy = 1'b0;
    tick();
    exp_e = sb.pop_front();
    reset = 1'b0;
    set_d(32'h9000, 32'd1, 32'd1, 4'b0110, 1'b0, 5'd0);
    md_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_e = sb.pop_front();
    end
    md_busy = 1'b0;
    tick();
    exp_e = sb.pop_front();
    checks++;
    if (md_stall_cycles !== 32'd6 || md_stall_events !== 16'd1) begin
      errors++; $display("FAIL perf got cyc=%0d ev=%0d exp cyc=6 ev=1", md_stall_cycles, md_stall_events);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pass_through();
    test_mult_mfhi();
    test_non_md_busy();
    test_boundary();
    test_eclr();
    test_reset_mid_stall();
    test_random();
`ifdef MD_PERF_CNT_EN
    test_perf();
`endif
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
